// File: rtl/m_clock_set_ctrl.sv
// rtl/m_clock_set_ctrl.sv - time-setting controller for the digital clock
//
// Purpose:
//   Samples the raw MODE and SET push-buttons once per scan tick, detects
//   presses, and steps a RUN -> SET_HOUR -> SET_MIN -> RUN mode machine.
//   Issues one-clk increment/clear strobes to the time counter datapath,
//   with hold-to-repeat on SET while in a setting mode.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   btn_mode  in   raw MODE button (bouncing, asynchronous)
//   btn_set   in   raw SET button (bouncing, asynchronous)
//   mode      out  2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN
//   run_en    out  time counters advance (RUN only)
//   inc_hour  out  one-clk strobe: increment hours
//   inc_min   out  one-clk strobe: increment minutes
//   clr_sec   out  one-clk strobe: clear seconds
module m_clock_set_ctrl #(
    parameter int TICK_DIV     = 16,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HOUR = 2'b01,
        S_MIN  = 2'b10
    } state_t;

    localparam logic [7:0] C_DELAY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] C_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);

    logic [TICK_DIV-1:0] r_div;
    logic                w_tick;
    logic                r_tick_d;

    logic                r_mode_cur;
    logic                r_mode_prev;
    logic                r_set_cur;
    logic                r_set_prev;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_rep_cnt;
    logic [7:0]          w_rep_cnt_nxt;
    logic [7:0]          w_rep_cnt_inc;
    logic                r_rep_arm;
    logic                w_rep_arm_nxt;

    logic                r_inc_hour;
    logic                r_inc_min;
    logic                r_clr_sec;
    logic                w_inc_hour_nxt;
    logic                w_inc_min_nxt;
    logic                w_clr_sec_nxt;

    logic                w_mode_press;
    logic                w_set_press;

    // Scan divider; the tick is the single cycle where it reads all-ones.
    assign w_tick = &r_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_div    <= r_div + 1'b1;
            r_tick_d <= w_tick;
        end
    end

    // Sampling only on the tick gives chatter rejection for free. Samples
    // reset to 1 so a button held through reset does not look like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_cur  <= 1'b1;
            r_mode_prev <= 1'b1;
            r_set_cur   <= 1'b1;
            r_set_prev  <= 1'b1;
        end else if (w_tick) begin
            r_mode_prev <= r_mode_cur;
            r_mode_cur  <= btn_mode;
            r_set_prev  <= r_set_cur;
            r_set_cur   <= btn_set;
        end
    end

    // Presses are only meaningful in the one cycle after a sampling edge.
    assign w_mode_press  = r_tick_d & r_mode_cur & ~r_mode_prev;
    assign w_set_press   = r_tick_d & r_set_cur  & ~r_set_prev;
    assign w_rep_cnt_inc = r_rep_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_rep_cnt  <= 8'd0;
            r_rep_arm  <= 1'b0;
            r_inc_hour <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr_sec  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_rep_arm  <= w_rep_arm_nxt;
            r_inc_hour <= w_inc_hour_nxt;
            r_inc_min  <= w_inc_min_nxt;
            r_clr_sec  <= w_clr_sec_nxt;
        end
    end

    // r_rep_arm is set only by a genuine SET press in a setting mode, so a
    // SET that was already held across a mode change (or reset) can never
    // start auto-repeating until it is released and pressed again.
    always_comb begin
        w_state_nxt    = r_state;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_rep_arm_nxt  = r_rep_arm;
        w_inc_hour_nxt = 1'b0;
        w_inc_min_nxt  = 1'b0;
        w_clr_sec_nxt  = 1'b0;

        if (r_tick_d) begin
            if (w_mode_press) begin
                // MODE has priority over a SET press on the same tick.
                case (r_state)
                    S_RUN: begin
                        w_state_nxt   = S_HOUR;
                        w_clr_sec_nxt = 1'b1;
                    end
                    S_HOUR:  w_state_nxt = S_MIN;
                    default: w_state_nxt = S_RUN;
                endcase
                w_rep_cnt_nxt = 8'd0;
                w_rep_arm_nxt = 1'b0;
            end else if (r_state == S_RUN) begin
                w_rep_cnt_nxt = 8'd0;
                w_rep_arm_nxt = 1'b0;
            end else if (w_set_press) begin
                w_inc_hour_nxt = (r_state == S_HOUR);
                w_inc_min_nxt  = (r_state == S_MIN);
                w_rep_cnt_nxt  = 8'd0;
                w_rep_arm_nxt  = 1'b1;
            end else if (r_set_cur && r_rep_arm) begin
                if (w_rep_cnt_inc == C_DELAY) begin
                    w_inc_hour_nxt = (r_state == S_HOUR);
                    w_inc_min_nxt  = (r_state == S_MIN);
                    // Reloading below the threshold sets the repeat rate.
                    w_rep_cnt_nxt  = C_RELOAD;
                end else begin
                    w_rep_cnt_nxt = w_rep_cnt_inc;
                end
            end else begin
                w_rep_cnt_nxt = 8'd0;
                w_rep_arm_nxt = 1'b0;
            end
        end
    end

    assign mode     = r_state;
    assign run_en   = (r_state == S_RUN);
    assign inc_hour = r_inc_hour;
    assign inc_min  = r_inc_min;
    assign clr_sec  = r_clr_sec;

endmodule

// File: tb/tb_m_clock_set_ctrl.sv
// tb/tb_m_clock_set_ctrl.sv - self-checking bench for m_clock_set_ctrl
module tb_m_clock_set_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_set;
    logic [1:0] mode;
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_clr  = 0;
    int cnt_hour = 0;
    int cnt_min  = 0;
    int viol     = 0;

    typedef struct {
        logic       bm;
        logic       bs;
        int         ticks;
        logic [1:0] exp_mode;
        logic       exp_run;
        int         exp_clr;
        int         exp_hour;
        int         exp_min;
    } vec_t;

    vec_t tbl1[24];
    vec_t tbl2[6];

    m_clock_set_ctrl #(
        .TICK_DIV     (4),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_set  (btn_set),
        .mode     (mode),
        .run_en   (run_en),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cnt_clr  <= cnt_clr  + int'(clr_sec);
        cnt_hour <= cnt_hour + int'(inc_hour);
        cnt_min  <= cnt_min  + int'(inc_min);
        if ((int'(clr_sec) + int'(inc_hour) + int'(inc_min)) > 1 || mode == 2'b11)
            viol <= viol + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Windows start at a negedge 4 clk after a sampling edge, so every
    // sampling edge in the window and its strobe cycle fall inside it.
    task automatic run_step(input string tag, input vec_t v);
        int c0, h0, m0;
        btn_mode = v.bm;
        btn_set  = v.bs;
        c0 = cnt_clr;
        h0 = cnt_hour;
        m0 = cnt_min;
        repeat (16 * v.ticks) @(negedge clk);
        check({tag, " mode"},     int'(mode),     int'(v.exp_mode));
        check({tag, " run_en"},   int'(run_en),   int'(v.exp_run));
        check({tag, " clr_sec"},  cnt_clr  - c0,  v.exp_clr);
        check({tag, " inc_hour"}, cnt_hour - h0,  v.exp_hour);
        check({tag, " inc_min"},  cnt_min  - m0,  v.exp_min);
    endtask

    task automatic release_and_align();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        int   c0;

        tbl1[0]  = '{1'b0, 1'b0, 12, 2'd0, 1'b1, 0, 0, 0};
        tbl1[1]  = '{1'b1, 1'b0, 1,  2'd1, 1'b0, 1, 0, 0};
        tbl1[2]  = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 0, 0, 0};
        tbl1[3]  = '{1'b0, 1'b1, 12, 2'd1, 1'b0, 0, 5, 0};
        tbl1[4]  = '{1'b0, 1'b0, 3,  2'd1, 1'b0, 0, 0, 0};
        tbl1[5]  = '{1'b1, 1'b0, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[6]  = '{1'b0, 1'b0, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[7]  = '{1'b0, 1'b1, 1,  2'd2, 1'b0, 0, 0, 1};
        tbl1[8]  = '{1'b0, 1'b0, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[9]  = '{1'b0, 1'b1, 6,  2'd2, 1'b0, 0, 0, 2};
        tbl1[10] = '{1'b0, 1'b0, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[11] = '{1'b1, 1'b0, 1,  2'd0, 1'b1, 0, 0, 0};
        tbl1[12] = '{1'b0, 1'b0, 1,  2'd0, 1'b1, 0, 0, 0};
        tbl1[13] = '{1'b0, 1'b1, 10, 2'd0, 1'b1, 0, 0, 0};
        tbl1[14] = '{1'b0, 1'b0, 1,  2'd0, 1'b1, 0, 0, 0};
        tbl1[15] = '{1'b1, 1'b1, 1,  2'd1, 1'b0, 1, 0, 0};
        tbl1[16] = '{1'b0, 1'b1, 6,  2'd1, 1'b0, 0, 0, 0};
        tbl1[17] = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 0, 0, 0};
        tbl1[18] = '{1'b0, 1'b1, 1,  2'd1, 1'b0, 0, 1, 0};
        tbl1[19] = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 0, 0, 0};
        tbl1[20] = '{1'b1, 1'b1, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[21] = '{1'b0, 1'b0, 1,  2'd2, 1'b0, 0, 0, 0};
        tbl1[22] = '{1'b1, 1'b0, 1,  2'd0, 1'b1, 0, 0, 0};
        tbl1[23] = '{1'b0, 1'b0, 1,  2'd0, 1'b1, 0, 0, 0};

        // After a reset taken with SET held high.
        tbl2[0]  = '{1'b0, 1'b1, 3,  2'd0, 1'b1, 0, 0, 0};
        tbl2[1]  = '{1'b1, 1'b1, 1,  2'd1, 1'b0, 1, 0, 0};
        tbl2[2]  = '{1'b0, 1'b1, 5,  2'd1, 1'b0, 0, 0, 0};
        tbl2[3]  = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 0, 0, 0};
        tbl2[4]  = '{1'b0, 1'b1, 1,  2'd1, 1'b0, 0, 1, 0};
        tbl2[5]  = '{1'b0, 1'b0, 1,  2'd1, 1'b0, 0, 0, 0};

        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset mode",     int'(mode),     0);
        check("reset run_en",   int'(run_en),   1);
        check("reset inc_hour", int'(inc_hour), 0);
        check("reset inc_min",  int'(inc_min),  0);
        check("reset clr_sec",  int'(clr_sec),  0);
        release_and_align();

        for (int i = 0; i < 24; i++) begin
            run_step($sformatf("t1[%0d]", i), tbl1[i]);
        end

        // MODE bouncing for 12 clk then stable high: exactly one advance.
        c0 = cnt_clr;
        for (int i = 0; i < 48; i++) begin
            btn_mode = (i < 12) ? (((i / 3) % 2) == 0) : 1'b1;
            @(negedge clk);
        end
        check("bounce mode",    int'(mode),    1);
        check("bounce clr_sec", cnt_clr - c0,  1);

        v = '{1'b0, 1'b0, 1, 2'd1, 1'b0, 0, 0, 0};
        run_step("bounce rel", v);
        v = '{1'b1, 1'b0, 1, 2'd2, 1'b0, 0, 0, 0};
        run_step("to min", v);
        v = '{1'b0, 1'b0, 1, 2'd2, 1'b0, 0, 0, 0};
        run_step("to min rel", v);
        v = '{1'b0, 1'b1, 5, 2'd2, 1'b0, 0, 0, 2};
        run_step("min repeat", v);

        // Reset lands mid-repeat with SET still held.
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst mode",     int'(mode),     0);
        check("async rst run_en",   int'(run_en),   1);
        check("async rst inc_min",  int'(inc_min),  0);
        check("async rst inc_hour", int'(inc_hour), 0);
        check("async rst clr_sec",  int'(clr_sec),  0);
        repeat (3) @(negedge clk);
        release_and_align();

        for (int i = 0; i < 6; i++) begin
            run_step($sformatf("t2[%0d]", i), tbl2[i]);
        end

        check("one strobe per cycle, legal mode", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
